// File: rtl/round_robin_mux_with_2_inputs_pkg.sv
// rr_mux_pkg: shared source type, source constants and round-robin winner function
package rr_mux_pkg;
   typedef logic [0:0] src_t;
   localparam src_t SRC_IN0 = 1'b0;
   localparam src_t SRC_IN1 = 1'b1;
   // Both non-empty: the source that did not win last time; otherwise whichever has data.
   function automatic src_t next_src(logic nonempty0, logic nonempty1, src_t last_src);
      return (nonempty0 && nonempty1) ? ~last_src : (nonempty1 ? SRC_IN1 : SRC_IN0);
   endfunction
endpackage

// File: rtl/round_robin_mux_with_2_inputs_if.sv
// round_robin_mux_with_2_inputs_if: two valid/ready input streams and one tagged output stream
//   in0_valid/in0_ready/in0_data, in1_valid/in1_ready/in1_data : input streams
//   out_valid/out_ready/out_data/out_src                         : merged output stream
//   master = traffic source/sink side, slave = mux side
interface round_robin_mux_with_2_inputs_if #(parameter int WIDTH = 8);
   import rr_mux_pkg::*;
   logic             in0_valid;
   logic             in0_ready;
   logic [WIDTH-1:0] in0_data;
   logic             in1_valid;
   logic             in1_ready;
   logic [WIDTH-1:0] in1_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   src_t             out_src;
   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, out_ready,
      input  in0_ready, in1_ready, out_valid, out_data, out_src
   );
   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
      output in0_ready, in1_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/round_robin_mux_with_2_inputs_fifo.sv
// flip_flop_fifo: register-based FIFO, DEPTH entries (power of 2, >= 2)
//   clk, rst (async, active-high), push, pop, write_data, read_data, empty, full
//   push is ignored while full, pop is ignored while empty (no bypass)
module flip_flop_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] write_data,
   output logic [WIDTH-1:0] read_data,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok, pop_ok;
   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty     = wr_ptr_q == rd_ptr_q;
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign read_data = mem_q[rd_ptr_q[AW-1:0]];
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
      for (int i = 0; i < DEPTH; i++)
         mem_d[i] = (push_ok && wr_ptr_q[AW-1:0] == AW'(i)) ? write_data : mem_q[i];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end
endmodule

// File: rtl/round_robin_mux_with_2_inputs.sv
// round_robin_mux_with_2_inputs: two buffered input streams merged round-robin into one registered output
//   clk, rst (async, active-high)
//   bus  : round_robin_mux_with_2_inputs_if.slave (in0/in1 valid-ready-data, out valid-ready-data-src)
//   grant_cnt0/grant_cnt1 : saturating per-source load counters, present only with RR_MUX_STATS_EN
module round_robin_mux_with_2_inputs
   import rr_mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
`ifdef RR_MUX_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input logic clk,
   input logic rst,
   round_robin_mux_with_2_inputs_if.slave bus
`ifdef RR_MUX_STATS_EN
   , output logic [CNT_W-1:0] grant_cnt0
   , output logic [CNT_W-1:0] grant_cnt1
`endif
);
   logic             empty0, full0, empty1, full1;
   logic [WIDTH-1:0] rd0, rd1;
   logic             load, pop0, pop1;
   src_t             win;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   src_t             out_src_q, out_src_d, last_src_q, last_src_d;
   // Ready comes straight from the registered full flag, never from out_ready.
   assign bus.in0_ready = !full0;
   assign bus.in1_ready = !full1;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   flip_flop_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .rst(rst), .push(bus.in0_valid && !full0), .pop(pop0),
      .write_data(bus.in0_data), .read_data(rd0), .empty(empty0), .full(full0)
   );
   flip_flop_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .rst(rst), .push(bus.in1_valid && !full1), .pop(pop1),
      .write_data(bus.in1_data), .read_data(rd1), .empty(empty1), .full(full1)
   );
   always_comb begin
      win         = next_src(!empty0, !empty1, last_src_q);
      load        = (!out_valid_q || bus.out_ready) && (!empty0 || !empty1);
      pop0        = load && win == SRC_IN0;
      pop1        = load && win == SRC_IN1;
      out_valid_d = load || (out_valid_q && !bus.out_ready);
      out_data_d  = load ? (win == SRC_IN1 ? rd1 : rd0) : out_data_q;
      out_src_d   = load ? win : out_src_q;
      last_src_d  = load ? win : last_src_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= SRC_IN0;
         last_src_q  <= SRC_IN1;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         last_src_q  <= last_src_d;
      end
   end
`ifdef RR_MUX_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
   always_comb begin
      cnt0_d = (pop0 && cnt0_q != '1) ? cnt0_q + CNT_W'(1) : cnt0_q;
      cnt1_d = (pop1 && cnt1_q != '1) ? cnt1_q + CNT_W'(1) : cnt1_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end
`endif
endmodule
